pipeline_step_controller: RTL and testbench
===========================================

Name: pipeline_step_controller

Overview:
- Sequences the MIPS pipeline for the debug unit: decides when the pipeline advances, resets or halts, and when a state dump goes out over UART.
- Takes decoded debugger commands through a valid/ready handshake and drives a one-cycle pipeline clock-enable (`pipe_en`) and `pipe_reset`.
- On every stop it raises `dump_req`, then waits for `dump_done` from the TX serializer.
- Supports run-to-end, step-N, halt and a single PC breakpoint on `PC_IFID`.

Parameters:
- PC_WIDTH, 10, width of the `pc_ifid` compare and of the breakpoint register.
- CYC_WIDTH, 16, width of the executed-cycle counter.
- RST_CYCLES, 2, number of `pipe_en` pulses issued with `pipe_reset` high.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_code  in  3  0 NOP, 1 PRESET, 2 RUN, 3 STEP, 4 HALT, 5 SET_BP, 6 CLR_BP, 7 reserved (treated as NOP)
- cmd_arg  in  PC_WIDTH  step count (STEP) or breakpoint PC (SET_BP)
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
- pc_ifid  in  PC_WIDTH  PC of IF/ID stage
- program_end  in  1  end-of-program detected
- dump_done  in  1  one-cycle pulse: TX serializer finished the dump
- pipe_en  out  1  one-cycle pipeline advance enable
- pipe_reset  out  1  pipeline synchronous reset
- dump_req  out  1  one-cycle dump request pulse
- halted  out  1  controller idle; pipeline frozen
- stop_reason  out  2  0 HALT/step-done, 1 END, 2 BREAKPOINT, 3 RESET-done
- cycle_count  out  CYC_WIDTH  `pipe_en` pulses since last PRESET, excluding reset pulses; saturates at all-ones
- state  out  3  FSM state, for LEDs

Behaviour:
- Reset values:
  - state IDLE; halted 1; cmd_ready 1.
  - pipe_en, pipe_reset, dump_req 0; stop_reason 0; cycle_count 0.
  - bp_enable 0, bp_pc 0, step counter 0, mode 0.
- States: IDLE(0), PRST(1), EXEC(2), CHECK(3), DUMP(4), WAIT_DUMP(5).
- cmd_ready is 1 in IDLE, EXEC and CHECK, and 0 elsewhere.
- In EXEC/CHECK only HALT is acted on; other accepted codes are dropped.
- IDLE command handling:
  - PRESET: go to PRST.
  - RUN: mode=run, go to EXEC.
  - STEP: mode=step; steps = cmd_arg, with 0 treated as 1; go to EXEC.
  - SET_BP: bp_pc=cmd_arg, bp_enable=1, stay IDLE.
  - CLR_BP: bp_enable=0, stay IDLE.
  - HALT and NOP: no effect.
- RUN or STEP accepted while program_end=1: no pipe_en is issued; go to DUMP with stop_reason=1.
- PRST:
  - pipe_reset=1 and pipe_en=1 for RST_CYCLES consecutive cycles.
  - Then pipe_reset=0, cycle_count cleared, stop_reason=3, go to DUMP.
- EXEC:
  - pipe_en=1 for exactly one cycle; cycle_count+1 (saturating).
  - In step mode, steps-1.
  - Go to CHECK.
- CHECK (pipe_en=0): evaluate in priority order; first match wins.
  1. program_end → stop_reason=1
  2. bp_enable && pc_ifid==bp_pc → stop_reason=2
  3. HALT accepted this cycle or in the preceding EXEC → stop_reason=0
  4. step mode && steps==0 → stop_reason=0
  5. otherwise → EXEC
  - Any stop goes to DUMP.
- The breakpoint is checked only in CHECK. RUN issued while pc_ifid==bp_pc therefore advances at least one cycle, which allows resume.
- DUMP: dump_req=1 for one cycle, then WAIT_DUMP.
- WAIT_DUMP:
  - Hold until dump_done=1, then IDLE with halted=1.
  - No timeout.
  - A dump_done outside WAIT_DUMP is ignored.
- halted=1 only in IDLE.
- Pipeline throughput is one pipe_en per 2 clocks in both run and step modes.
- Reset mid-operation: all state returns to reset values on the next edge.
  - The breakpoint is lost.
  - Any pending dump is abandoned; no dump_req is issued.

Test Plan:
- Reset, then PRESET → pipe_reset=1 and pipe_en=1 for exactly 2 cycles, one dump_req with stop_reason=3, cycle_count=0; after dump_done pulse, halted=1.
- STEP arg=3 with program_end=0 → exactly 3 pipe_en pulses spaced 2 clocks apart, dump_req once, stop_reason=0, cycle_count=3; STEP arg=0 → exactly 1 pulse.
- SET_BP 0x008, RUN, with pc_ifid model incrementing by 4 per pulse from 0 → stops after the pulse that makes pc_ifid=8 (2 pulses), stop_reason=2; a second RUN advances past 8 without stopping there.
- RUN; program_end asserted after pulse 5 while the breakpoint also matches the same PC → stop_reason=1 (END wins), cycle_count=5.
- RUN, then HALT during CHECK → no further pipe_en, dump_req, stop_reason=0; STEP accepted while program_end=1 → zero pipe_en, stop_reason=1.
- Reset asserted in WAIT_DUMP and mid-PRST → next cycle halted=1, pipe_reset=0, bp_enable=0, no dump_req; a stray dump_done in IDLE is ignored.

Source files
------------

// File: rtl/pipeline_step_controller.sv
// Debug-unit pipeline sequencer: reset, run, step, halt and breakpoint
// control of the MIPS pipeline, with a UART state dump after every stop.
module pipeline_step_controller #(
    parameter int PC_WIDTH   = 10,
    parameter int CYC_WIDTH  = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd_code,
    input  logic [PC_WIDTH-1:0]  cmd_arg,
    output logic                 cmd_ready,
    input  logic [PC_WIDTH-1:0]  pc_ifid,
    input  logic                 program_end,
    input  logic                 dump_done,
    output logic                 pipe_en,
    output logic                 pipe_reset,
    output logic                 dump_req,
    output logic                 halted,
    output logic [1:0]           stop_reason,
    output logic [CYC_WIDTH-1:0] cycle_count,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRST      = 3'd1,
        S_EXEC      = 3'd2,
        S_CHECK     = 3'd3,
        S_DUMP      = 3'd4,
        S_WAIT_DUMP = 3'd5
    } state_t;

    localparam logic [2:0] C_PRESET = 3'd1;
    localparam logic [2:0] C_RUN    = 3'd2;
    localparam logic [2:0] C_STEP   = 3'd3;
    localparam logic [2:0] C_HALT   = 3'd4;
    localparam logic [2:0] C_SET_BP = 3'd5;
    localparam logic [2:0] C_CLR_BP = 3'd6;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t                cur_st, nxt_st;
    logic                  bp_enable, bp_enable_n;
    logic [PC_WIDTH-1:0]   bp_pc, bp_pc_n;
    logic [PC_WIDTH-1:0]   steps, steps_n;
    logic                  mode_step, mode_step_n;
    logic                  halt_pend, halt_pend_n;
    logic [1:0]            stop_r, stop_n;
    logic [CYC_WIDTH-1:0]  cyc_r, cyc_n;
    logic [RCW-1:0]        rst_cnt, rst_cnt_n;

    logic cmd_acc;
    logic halt_cmd;
    logic bp_hit;

    assign cmd_acc  = cmd_valid && cmd_ready;
    assign halt_cmd = cmd_acc && (cmd_code == C_HALT);
    assign bp_hit   = bp_enable && (pc_ifid == bp_pc);

    assign cmd_ready   = (cur_st == S_IDLE) || (cur_st == S_EXEC) ||
                         (cur_st == S_CHECK);
    assign pipe_en     = (cur_st == S_EXEC) || (cur_st == S_PRST);
    assign pipe_reset  = (cur_st == S_PRST);
    assign dump_req    = (cur_st == S_DUMP);
    assign halted      = (cur_st == S_IDLE);
    assign stop_reason = stop_r;
    assign cycle_count = cyc_r;
    assign state       = cur_st;

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_st    <= S_IDLE;
            bp_enable <= 1'b0;
            bp_pc     <= '0;
            steps     <= '0;
            mode_step <= 1'b0;
            halt_pend <= 1'b0;
            stop_r    <= 2'd0;
            cyc_r     <= '0;
            rst_cnt   <= '0;
        end else begin
            cur_st    <= nxt_st;
            bp_enable <= bp_enable_n;
            bp_pc     <= bp_pc_n;
            steps     <= steps_n;
            mode_step <= mode_step_n;
            halt_pend <= halt_pend_n;
            stop_r    <= stop_n;
            cyc_r     <= cyc_n;
            rst_cnt   <= rst_cnt_n;
        end
    end

    always_comb begin
        nxt_st      = cur_st;
        bp_enable_n = bp_enable;
        bp_pc_n     = bp_pc;
        steps_n     = steps;
        mode_step_n = mode_step;
        halt_pend_n = halt_pend;
        stop_n      = stop_r;
        cyc_n       = cyc_r;
        rst_cnt_n   = rst_cnt;
        unique case (cur_st)
            S_IDLE: begin
                halt_pend_n = 1'b0;
                if (cmd_acc) begin
                    case (cmd_code)
                        C_PRESET: begin
                            nxt_st    = S_PRST;
                            rst_cnt_n = '0;
                        end
                        C_RUN, C_STEP: begin
                            mode_step_n = (cmd_code == C_STEP);
                            steps_n     = (cmd_arg == '0) ?
                                          PC_WIDTH'(1) : cmd_arg;
                            // Already at the end: report it without advancing
                            if (program_end) begin
                                nxt_st = S_DUMP;
                                stop_n = 2'd1;
                            end else begin
                                nxt_st = S_EXEC;
                            end
                        end
                        C_SET_BP: begin
                            bp_pc_n     = cmd_arg;
                            bp_enable_n = 1'b1;
                        end
                        C_CLR_BP: bp_enable_n = 1'b0;
                        default: ;
                    endcase
                end
            end
            S_PRST: begin
                if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
                    nxt_st = S_DUMP;
                    cyc_n  = '0;
                    stop_n = 2'd3;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            S_EXEC: begin
                cyc_n = (cyc_r == '1) ? cyc_r : cyc_r + 1'b1;
                if (mode_step)
                    steps_n = steps - 1'b1;
                if (halt_cmd)
                    halt_pend_n = 1'b1;
                nxt_st = S_CHECK;
            end
            S_CHECK: begin
                nxt_st = S_DUMP;
                if (program_end)
                    stop_n = 2'd1;
                else if (bp_hit)
                    stop_n = 2'd2;
                else if (halt_pend || halt_cmd)
                    stop_n = 2'd0;
                else if (mode_step && steps == '0)
                    stop_n = 2'd0;
                else
                    nxt_st = S_EXEC;
            end
            S_DUMP: nxt_st = S_WAIT_DUMP;
            S_WAIT_DUMP: begin
                if (dump_done)
                    nxt_st = S_IDLE;
            end
            default: nxt_st = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Scoreboard bench for pipeline_step_controller: each command predicts its
// dump (reason, cycle count, pulse counts); a monitor checks every dump_req.
module tb_pipeline_step_controller;

    localparam int PW  = 10;
    localparam int CW  = 16;
    localparam int RST = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_code = 3'd0;
    logic [PW-1:0] cmd_arg = '0;
    logic          cmd_ready;
    logic [PW-1:0] pc_ifid;
    logic          program_end;
    logic          dump_done;
    logic          pipe_en;
    logic          pipe_reset;
    logic          dump_req;
    logic          halted;
    logic [1:0]    stop_reason;
    logic [CW-1:0] cycle_count;
    logic [2:0]    state;

    pipeline_step_controller #(
        .PC_WIDTH(PW), .CYC_WIDTH(CW), .RST_CYCLES(RST)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .cmd_arg(cmd_arg), .cmd_ready(cmd_ready),
        .pc_ifid(pc_ifid), .program_end(program_end),
        .dump_done(dump_done), .pipe_en(pipe_en), .pipe_reset(pipe_reset),
        .dump_req(dump_req), .halted(halted), .stop_reason(stop_reason),
        .cycle_count(cycle_count), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int reason;
        int cc;
        int pulses;
        int rpulses;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int failed = 0;

    // pipeline model: pc advances by 4 per non-reset pulse
    int p = 0;
    int end_at = 1000000;
    logic done_r = 1'b0;
    logic stray_r = 1'b0;
    logic auto_done = 1'b1;
    assign dump_done   = done_r | stray_r;
    assign pc_ifid     = PW'(p * 4);
    assign program_end = (p >= end_at);

    always @(posedge clock)
        if (pipe_en === 1'b1)
            p <= (pipe_reset === 1'b1) ? 0 : p + 1;

    // reference state
    bit bp_en_m = 0;
    int bp_m = 0;
    int cc_m = 0;
    int stop_m = 0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor
    int op_p = 0;
    int op_r = 0;
    bit prev_en = 0;
    always @(negedge clock) begin
        if (pipe_en === 1'b1) begin
            check("en_spacing", int'(prev_en && !pipe_reset), 0);
            op_p++;
            if (pipe_reset === 1'b1)
                op_r++;
        end
        if (dump_req === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_dump", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dump_reason", int'(stop_reason), e.reason);
                check("dump_cycles", int'(cycle_count), e.cc);
                check("dump_pulses", op_p, e.pulses);
                check("dump_rst_pulses", op_r, e.rpulses);
            end
            op_p = 0;
            op_r = 0;
        end
        if (reset === 1'b1) begin
            op_p = 0;
            op_r = 0;
        end
        prev_en = (pipe_en === 1'b1);
    end

    initial begin
        forever begin
            @(negedge clock);
            if (dump_req === 1'b1 && auto_done) begin
                repeat ($urandom_range(1, 4)) @(negedge clock);
                done_r = 1'b1;
                @(negedge clock);
                done_r = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stop rules applied pulse by pulse from the current pipeline position.
    function automatic void predict(input bit step, input int n,
                                    input int haltk, output int pulses,
                                    output int reason);
        int nn;
        nn = (n == 0) ? 1 : n;
        pulses = 0;
        reason = 0;
        if (p >= end_at) begin
            reason = 1;
            return;
        end
        for (int k = 1; k < 4096; k++) begin
            int q;
            q = p + k;
            pulses = k;
            if (q >= end_at) begin reason = 1; return; end
            if (bp_en_m && (((q * 4) % 1024) == bp_m)) begin
                reason = 2;
                return;
            end
            if (haltk == k) begin reason = 0; return; end
            if (step && k == nn) begin reason = 0; return; end
        end
    endfunction

    task automatic send(int code, int arg);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_code  = 3'(code);
        cmd_arg   = PW'(arg);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100)
            check("cmd_ready_timeout", 0, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_code  = 3'd0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (halted !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000)
            check("idle_timeout", 0, 1);
    endtask

    task automatic do_op(int code, int arg, int haltk, bit halt_in_check);
        exp_t e;
        int pl, rs, hk;
        hk = haltk;
        if (code == 2 || code == 3) begin
            predict(code == 3, arg, 0, pl, rs);
            if (hk > pl)
                hk = 0;
            predict(code == 3, arg, hk, pl, rs);
            cc_m = (cc_m + pl > 65535) ? 65535 : cc_m + pl;
            stop_m = rs;
            e = '{reason: rs, cc: cc_m, pulses: pl, rpulses: 0};
            sb.push_back(e);
        end else if (code == 1) begin
            cc_m = 0;
            stop_m = 3;
            e = '{reason: 3, cc: 0, pulses: RST, rpulses: RST};
            sb.push_back(e);
        end else if (code == 5) begin
            bp_en_m = 1;
            bp_m = arg % 1024;
        end else if (code == 6) begin
            bp_en_m = 0;
        end
        send(code, arg);
        if (hk > 0) begin
            int k, n;
            k = 0;
            n = 0;
            while (n < 500) begin
                if (pipe_en === 1'b1)
                    k++;
                if (k == hk)
                    break;
                @(negedge clock);
                n++;
            end
            if (n >= 500)
                check("halt_wait_timeout", 0, 1);
            if (halt_in_check)
                @(negedge clock);
            cmd_valid = 1'b1;
            cmd_code  = 3'd4;
            @(negedge clock);
            cmd_valid = 1'b0;
            cmd_code  = 3'd0;
        end
        wait_idle();
        check("idle_halted", int'(halted), 1);
        check("idle_reason", int'(stop_reason), stop_m);
        check("idle_cycles", int'(cycle_count), cc_m);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        check("rst_halted", int'(halted), 1);
        check("rst_pipe_reset", int'(pipe_reset), 0);
        check("rst_pipe_en", int'(pipe_en), 0);
        check("rst_dump_req", int'(dump_req), 0);
        check("rst_state", int'(state), 0);
        check("rst_reason", int'(stop_reason), 0);
        check("rst_cycles", int'(cycle_count), 0);
        @(negedge clock);
        reset = 1'b0;
        bp_en_m = 0;
        bp_m = 0;
        cc_m = 0;
        stop_m = 0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_halted", int'(halted), 1);
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_pipe_en", int'(pipe_en), 0);
        check("reset_pipe_reset", int'(pipe_reset), 0);
        check("reset_dump_req", int'(dump_req), 0);
        check("reset_reason", int'(stop_reason), 0);
        check("reset_cycles", int'(cycle_count), 0);
        check("reset_state", int'(state), 0);
        reset = 1'b0;
        @(negedge clock);

        do_op(1, 0, 0, 0);
        end_at = 1000000;
        do_op(3, 3, 0, 0);
        do_op(3, 0, 0, 0);

        do_op(1, 0, 0, 0);
        do_op(5, 8, 0, 0);
        do_op(2, 0, 0, 0);
        end_at = p + 5;
        do_op(2, 0, 0, 0);

        do_op(1, 0, 0, 0);
        do_op(5, 20, 0, 0);
        end_at = 5;
        do_op(2, 0, 0, 0);

        do_op(6, 0, 0, 0);
        end_at = p + 1000;
        do_op(2, 0, 3, 1);
        end_at = p + 1000;
        do_op(2, 0, 2, 0);
        end_at = p;
        do_op(3, 3, 0, 0);
        do_op(2, 0, 0, 0);

        // reset while waiting for the dump to finish
        do_op(5, 8, 0, 0);
        auto_done = 1'b0;
        sb.push_back('{reason: 3, cc: 0, pulses: RST, rpulses: RST});
        send(1, 0);
        n = 0;
        while (state !== 3'd5 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("reach_wait_dump", int'(state), 5);
        pulse_reset();
        auto_done = 1'b1;
        end_at = p + 4;
        do_op(2, 0, 0, 0);

        // reset in the middle of the pipeline reset sequence
        send(1, 0);
        check("prst_pipe_reset", int'(pipe_reset), 1);
        pulse_reset();
        repeat (6) @(negedge clock);
        check("prst_abandon_idle", int'(halted), 1);

        // a dump_done pulse while idle must be ignored
        stray_r = 1'b1;
        @(negedge clock);
        stray_r = 1'b0;
        repeat (3) @(negedge clock);
        check("stray_halted", int'(halted), 1);
        check("stray_state", int'(state), 0);
        end_at = p + 1000;
        do_op(3, 2, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int c;
            c = $urandom_range(0, 7);
            end_at = p + $urandom_range(0, 15);
            case (c)
                2: do_op(2, 0, ($urandom_range(0, 1) == 1) ?
                         $urandom_range(1, 6) : 0, 1'($urandom_range(0, 1)));
                3: do_op(3, $urandom_range(0, 6), 0, 0);
                5: do_op(5, ((p + $urandom_range(1, 6)) * 4) % 1024, 0, 0);
                default: do_op(c, $urandom_range(0, 1023), 0, 0);
            endcase
        end

        repeat (4) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
